// File: rtl/axis_input_skid_pkg.sv
// rtl/axis_input_skid_pkg.sv - shared beat geometry, tuser layout and skid constants
package axis_input_skid_pkg;

    localparam int ROWS                 = 4;
    localparam int COLS                 = 4;
    localparam int WORD_WIDTH           = 8;
    localparam int INPUT_SKID_CNT_WIDTH = 32;

    // Per-beat control qualifiers; only meaningful while the beat is valid.
    typedef struct packed {
        logic is_config;
        logic is_top_block;
        logic is_bot_block;
        logic is_cin_last;
        logic is_sum_start;
        logic is_w_last;
    } tuser_st;

    // Skid occupancy encoded as {skid_valid, main_valid}.
    localparam logic [1:0] SKID_EMPTY = 2'b00;
    localparam logic [1:0] SKID_FULL1 = 2'b01;
    localparam logic [1:0] SKID_FULL2 = 2'b11;

endpackage

// File: rtl/axis_input_skid_core.sv
// rtl/axis_input_skid_core.sv - generic two-entry registered skid buffer
module axis_skid_core
    import axis_input_skid_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         s_tvalid_i,
    output logic         s_tready_o,
    input  logic [W-1:0] s_tdata_i,
    output logic         m_tvalid_o,
    input  logic         m_tready_i,
    output logic [W-1:0] m_tdata_o
);

    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         ready_q;
    logic [W-1:0] main_data_q;
    logic [W-1:0] skid_data_q;
    logic         load_main;
    logic         load_skid;
    logic         skid_to_main;
    logic         s_hs;
    logic         m_hs;

    assign s_hs       = s_tvalid_i & ready_q;
    assign m_hs       = main_valid_q & m_tready_i;
    assign s_tready_o = ready_q;
    assign m_tvalid_o = main_valid_q;
    assign m_tdata_o  = main_data_q;

    // Next occupancy and data-move strobes from the current occupancy and both handshakes.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        unique case ({skid_valid_q, main_valid_q})
            SKID_EMPTY: begin
                if (s_hs) begin
                    main_valid_d = 1'b1;
                    load_main    = 1'b1;
                end
            end
            SKID_FULL1: begin
                if (s_hs && m_hs) begin
                    load_main = 1'b1;
                end else if (s_hs) begin
                    skid_valid_d = 1'b1;
                    load_skid    = 1'b1;
                end else if (m_hs) begin
                    main_valid_d = 1'b0;
                end
            end
            SKID_FULL2: begin
                // ready is low here, so only the downstream side can move.
                if (m_hs) begin
                    skid_valid_d = 1'b0;
                    skid_to_main = 1'b1;
                end
            end
            default: begin
                // Skid without main is unreachable; recover to empty.
                main_valid_d = 1'b0;
                skid_valid_d = 1'b0;
            end
        endcase
    end

    // Occupancy and the registered ready; ready tracks the next skid state so it never sees m_tready combinationally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ~skid_valid_d;
        end
    end

    // Beat payload registers; contents are qualified by the valid bits so they need no reset.
    always_ff @(posedge clk_i) begin
        if (load_main) begin
            main_data_q <= s_tdata_i;
        end else if (skid_to_main) begin
            main_data_q <= skid_data_q;
        end
        if (load_skid) begin
            skid_data_q <= s_tdata_i;
        end
    end

endmodule

// File: rtl/axis_input_skid.sv
// rtl/axis_input_skid.sv - input register slice with debug counters and stability checker
module axis_input_skid
    import axis_input_skid_pkg::*;
#(
    parameter int ROWS       = axis_input_skid_pkg::ROWS,
    parameter int COLS       = axis_input_skid_pkg::COLS,
    parameter int WORD_WIDTH = axis_input_skid_pkg::WORD_WIDTH,
    parameter int CNT_WIDTH  = INPUT_SKID_CNT_WIDTH
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    input  tuser_st                    s_axis_tuser,
    input  logic [WORD_WIDTH*ROWS-1:0] s_axis_pixels_tdata,
    input  logic [WORD_WIDTH*COLS-1:0] s_axis_weights_tdata,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    output tuser_st                    m_axis_tuser,
    output logic [WORD_WIDTH*ROWS-1:0] m_axis_pixels_tdata,
    output logic [WORD_WIDTH*COLS-1:0] m_axis_weights_tdata,
    input  logic                       cnt_clear,
    output logic [CNT_WIDTH-1:0]       beat_count,
    output logic [CNT_WIDTH-1:0]       pkt_count,
    output logic                       err_unstable
);

    localparam int PW  = WORD_WIDTH * ROWS;
    localparam int WW  = WORD_WIDTH * COLS;
    localparam int TUW = $bits(tuser_st);
    localparam int BW  = 1 + TUW + WW + PW;

    logic [BW-1:0]        s_beat;
    logic [BW-1:0]        m_beat;
    logic [BW-1:0]        prev_beat_q;
    logic                 prev_stall_q;
    logic                 stall_now;
    logic                 violation;
    logic                 m_hs;
    logic [CNT_WIDTH-1:0] beat_count_q, beat_count_d;
    logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
    logic                 err_q, err_d;

    assign s_beat = {s_axis_tlast, s_axis_tuser, s_axis_weights_tdata, s_axis_pixels_tdata};
    assign {m_axis_tlast, m_axis_tuser, m_axis_weights_tdata, m_axis_pixels_tdata} = m_beat;

    axis_skid_core #(
        .W (BW)
    ) u_core (
        .clk_i      (aclk),
        .rst_ni     (aresetn),
        .s_tvalid_i (s_axis_tvalid),
        .s_tready_o (s_axis_tready),
        .s_tdata_i  (s_beat),
        .m_tvalid_o (m_axis_tvalid),
        .m_tready_i (m_axis_tready),
        .m_tdata_o  (m_beat)
    );

    assign m_hs      = m_axis_tvalid & m_axis_tready;
    assign stall_now = s_axis_tvalid & ~s_axis_tready;
    // A stalled beat must reappear next cycle, still valid and bit-identical.
    assign violation = prev_stall_q & (~s_axis_tvalid | (s_beat != prev_beat_q));

    // Counter and sticky-error next state; clear beats increment.
    always_comb begin
        beat_count_d = beat_count_q;
        pkt_count_d  = pkt_count_q;
        err_d        = err_q;
        if (cnt_clear) begin
            beat_count_d = '0;
            pkt_count_d  = '0;
            err_d        = 1'b0;
        end else begin
            if (m_hs) begin
                beat_count_d = beat_count_q + CNT_WIDTH'(1);
                if (m_axis_tlast) begin
                    pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
                end
            end
            if (violation) begin
                err_d = 1'b1;
            end
        end
    end

    // Counters, error flag and the stall marker used by the stability check.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_count_q <= '0;
            pkt_count_q  <= '0;
            err_q        <= 1'b0;
            prev_stall_q <= 1'b0;
        end else begin
            beat_count_q <= beat_count_d;
            pkt_count_q  <= pkt_count_d;
            err_q        <= err_d;
            prev_stall_q <= stall_now;
        end
    end

    // Snapshot of the offered beat, compared only when the previous cycle stalled.
    always_ff @(posedge aclk) begin
        prev_beat_q <= s_beat;
    end

    assign beat_count   = beat_count_q;
    assign pkt_count    = pkt_count_q;
    assign err_unstable = err_q;

endmodule

// File: tb/tb_axis_input_skid.sv
// tb/tb_axis_input_skid.sv - self-checking bench for axis_input_skid
module tb_axis_input_skid;
    import axis_input_skid_pkg::*;

    localparam int PW  = WORD_WIDTH * ROWS;
    localparam int WW  = WORD_WIDTH * COLS;
    localparam int TUW = $bits(tuser_st);

    typedef struct packed {
        logic              tlast;
        tuser_st           tuser;
        logic [WW-1:0]     wts;
        logic [PW-1:0]     pix;
    } beat_t;

    typedef struct {
        bit offer;
        bit rdy;
        bit exp_s_tready;
        bit exp_m_tvalid;
    } vec_t;

    logic          aclk;
    logic          aresetn;
    logic          s_axis_tready;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    tuser_st       s_axis_tuser;
    logic [PW-1:0] s_axis_pixels_tdata;
    logic [WW-1:0] s_axis_weights_tdata;
    logic          m_axis_tready;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    tuser_st       m_axis_tuser;
    logic [PW-1:0] m_axis_pixels_tdata;
    logic [WW-1:0] m_axis_weights_tdata;
    logic          cnt_clear;
    logic [31:0]   beat_count;
    logic [31:0]   pkt_count;
    logic          err_unstable;

    axis_input_skid dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .s_axis_tready        (s_axis_tready),
        .s_axis_tvalid        (s_axis_tvalid),
        .s_axis_tlast         (s_axis_tlast),
        .s_axis_tuser         (s_axis_tuser),
        .s_axis_pixels_tdata  (s_axis_pixels_tdata),
        .s_axis_weights_tdata (s_axis_weights_tdata),
        .m_axis_tready        (m_axis_tready),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tlast         (m_axis_tlast),
        .m_axis_tuser         (m_axis_tuser),
        .m_axis_pixels_tdata  (m_axis_pixels_tdata),
        .m_axis_weights_tdata (m_axis_weights_tdata),
        .cnt_clear            (cnt_clear),
        .beat_count           (beat_count),
        .pkt_count            (pkt_count),
        .err_unstable         (err_unstable)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    beat_t sb[$];
    int    n_cmp     = 0;
    int    n_err     = 0;
    int    n_sent    = 0;
    int    n_tlast   = 0;
    int    n_cfg_out = 0;
    bit    hs_seen   = 1'b0;
    bit    cfg_next  = 1'b0;

    beat_t             mon_exp;
    beat_t             mon_act;
    logic [$bits(beat_t)-1:0] mon_mask;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic new_beat();
        logic [TUW-1:0] u;
        for (int i = 0; i < ROWS; i++) s_axis_pixels_tdata[i*WORD_WIDTH +: WORD_WIDTH] = WORD_WIDTH'($urandom);
        for (int i = 0; i < COLS; i++) s_axis_weights_tdata[i*WORD_WIDTH +: WORD_WIDTH] = WORD_WIDTH'($urandom);
        s_axis_tlast = ($urandom_range(3) == 0);
        u = TUW'($urandom);
        s_axis_tuser = u;
        s_axis_tuser.is_config = cfg_next;
    endtask

    // One cycle of upstream/downstream drive; an unaccepted beat is held unchanged.
    task automatic step(input bit offer, input bit rdy);
        @(posedge aclk);
        #1;
        if (s_axis_tvalid && !hs_seen) begin
            s_axis_tvalid = 1'b1;
        end else if (offer) begin
            new_beat();
            s_axis_tvalid = 1'b1;
        end else begin
            s_axis_tvalid = 1'b0;
        end
        m_axis_tready = rdy;
    endtask

    task automatic drain();
        int c = 0;
        do begin
            step(1'b0, 1'b1);
            @(negedge aclk);
            c++;
        end while ((m_axis_tvalid || s_axis_tvalid) && c < 200);
        if (c >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d cycles required under 200", c);
        end
        #1;
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard: push on s handshake, pop and compare on m handshake.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_underflow: got unexpected beat, required none");
                end else begin
                    mon_exp  = sb.pop_front();
                    mon_act  = {m_axis_tlast, m_axis_tuser, m_axis_weights_tdata, m_axis_pixels_tdata};
                    mon_mask = '1;
                    if (mon_exp.tuser.is_config) mon_mask[PW-1:0] = '0;
                    n_cmp++;
                    if ((mon_act & mon_mask) !== (mon_exp & mon_mask)) begin
                        n_err++;
                        $display("FAIL beat_data: got %0h required %0h", mon_act, mon_exp);
                    end
                    if (mon_act.tuser.is_config) n_cfg_out++;
                end
            end
            if (s_axis_tvalid && s_axis_tready) begin
                sb.push_back({s_axis_tlast, s_axis_tuser, s_axis_weights_tdata, s_axis_pixels_tdata});
                n_sent++;
                if (s_axis_tlast) n_tlast++;
            end
            hs_seen = s_axis_tvalid && s_axis_tready;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   sent0;
        int   tlast0;
        int   cfg0;
        int   cyc;

        vecs[0] = '{1, 0, 1, 0};
        vecs[1] = '{1, 0, 1, 1};
        vecs[2] = '{1, 0, 0, 1};
        vecs[3] = '{1, 1, 0, 1};
        vecs[4] = '{1, 1, 1, 1};
        vecs[5] = '{1, 1, 1, 1};
        vecs[6] = '{0, 1, 1, 1};
        vecs[7] = '{0, 1, 1, 0};

        aresetn              = 1'b0;
        s_axis_tvalid        = 1'b0;
        s_axis_tlast         = 1'b0;
        s_axis_tuser         = '0;
        s_axis_pixels_tdata  = '0;
        s_axis_weights_tdata = '0;
        m_axis_tready        = 1'b0;
        cnt_clear            = 1'b0;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_beat_count", 64'(beat_count), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_err", 64'(err_unstable), 64'd0);
        #1;
        aresetn = 1'b1;
        #1;
        check("rel_s_tready_before_edge", 64'(s_axis_tready), 64'd0);

        // Test 1: streaming at full rate
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1);
            @(negedge aclk);
            check("t1_s_tready", 64'(s_axis_tready), 64'd1);
            if (i == 0) check("t1_latency", 64'(m_axis_tvalid), 64'd0);
            else        check("t1_no_bubble", 64'(m_axis_tvalid), 64'd1);
        end
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        @(negedge aclk);
        check("t1_beat_count", 64'(beat_count), 64'd16);
        check("t1_m_tvalid_idle", 64'(m_axis_tvalid), 64'd0);

        // Test 2: stall table
        foreach (vecs[i]) begin
            step(vecs[i].offer, vecs[i].rdy);
            @(negedge aclk);
            check($sformatf("t2_s_tready[%0d]", i), 64'(s_axis_tready), 64'(vecs[i].exp_s_tready));
            check($sformatf("t2_m_tvalid[%0d]", i), 64'(m_axis_tvalid), 64'(vecs[i].exp_m_tvalid));
        end
        drain();
        check("t2_beat_count", 64'(beat_count), 64'd20);

        // Test 3: random valid/ready
        cnt_clear = 1'b1;
        step(1'b0, 1'b1);
        cnt_clear = 1'b0;
        @(negedge aclk);
        check("t3_clear_beat_count", 64'(beat_count), 64'd0);
        sent0  = n_sent;
        tlast0 = n_tlast;
        cyc    = 0;
        while ((n_sent - sent0) < 10000 && cyc < 60000) begin
            step(1'($urandom_range(1)), 1'($urandom_range(1)));
            cyc++;
        end
        if (cyc >= 60000) begin
            n_cmp++;
            n_err++;
            $display("FAIL t3_timeout: got %0d beats required 10000", n_sent - sent0);
        end
        drain();
        check("t3_beat_count", 64'(beat_count), 64'(n_sent - sent0));
        check("t3_pkt_count", 64'(pkt_count), 64'(n_tlast - tlast0));
        check("t3_err_clean", 64'(err_unstable), 64'd0);

        // Test 4: config beat between data beats
        cfg0 = n_cfg_out;
        step(1'b1, 1'b1);
        cfg_next = 1'b1;
        step(1'b1, 1'b1);
        cfg_next = 1'b0;
        step(1'b1, 1'b1);
        drain();
        check("t4_cfg_seen", 64'(n_cfg_out - cfg0), 64'd1);

        // Test 5: valid dropped while stalled
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        @(negedge aclk);
        check("t5_stalled_ready", 64'(s_axis_tready), 64'd0);
        check("t5_err_before", 64'(err_unstable), 64'd0);
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        @(negedge aclk);
        check("t5_err_not_yet", 64'(err_unstable), 64'd0);
        step(1'b0, 1'b0);
        @(negedge aclk);
        check("t5_err_set", 64'(err_unstable), 64'd1);
        step(1'b0, 1'b0);
        @(negedge aclk);
        check("t5_err_sticky", 64'(err_unstable), 64'd1);
        cnt_clear = 1'b1;
        step(1'b0, 1'b0);
        cnt_clear = 1'b0;
        @(negedge aclk);
        check("t5_err_cleared", 64'(err_unstable), 64'd0);
        check("t5_beat_cleared", 64'(beat_count), 64'd0);
        check("t5_pkt_cleared", 64'(pkt_count), 64'd0);
        drain();
        check("t5_beat_after_drain", 64'(beat_count), 64'd2);

        // Test 6: reset with two beats buffered
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        @(posedge aclk);
        #3;
        aresetn = 1'b0;
        #1;
        check("t6_m_tvalid_async", 64'(m_axis_tvalid), 64'd0);
        check("t6_s_tready_async", 64'(s_axis_tready), 64'd0);
        sb.delete();
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        hs_seen       = 1'b0;
        @(negedge aclk);
        #1;
        aresetn = 1'b1;
        check("t6_beat_count_rst", 64'(beat_count), 64'd0);
        check("t6_ready_before_edge", 64'(s_axis_tready), 64'd0);
        step(1'b1, 1'b1);
        @(negedge aclk);
        check("t6_ready_after_edge", 64'(s_axis_tready), 64'd1);
        step(1'b1, 1'b1);
        drain();
        check("t6_beat_count", 64'(beat_count), 64'd2);

        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
